ysyx_25040111_csr_seq: RTL
==========================

// Module: ysyx_25040111_csr_seq
// PURPOSE
//  Multi-cycle sequencer between the decode stage and the CSR register file. Accepts one decoded
//  CSR/trap instruction per handshake and drives the CSR file's single read and single write port.
//  Returns rd writeback data and the next-PC redirect to writeback.
//  Handles CSRRW/CSRRS/CSRRC (register and zimm forms), ECALL and MRET.
// PARAMETERS
//  XLEN       32      datapath width; only 32 is supported
//  A_MTVEC    12'h305 mtvec address
//  A_MEPC     12'h341 mepc address
// PORTS
//  clk         in   1   clock
//  reset       in   1   synchronous, active-high reset
//  in_valid    in   1   decode holds a valid instruction
//  in_ready    out  1   sequencer can accept; high only in IDLE
//  in_op       in   3   0 NOP,1 CSRRW,2 CSRRS,3 CSRRC,4 ECALL,5 MRET,6-7 reserved
//  in_csr      in   12  CSR address (CSR ops only)
//  in_src      in   32  rs1 value or zero-extended zimm
//  in_pc       in   32  PC of the instruction
//  in_rd       in   5   destination register index
//  out_valid   out  1   result valid in DONE
//  out_ready   in   1   writeback accepts result
//  out_rd      out  5   destination index
//  out_rd_wen  out  1   write rd (CSR ops with rd!=0)
//  out_rdata   out  32  old CSR value for rd
//  out_redir   out  1   PC redirect (ECALL/MRET)
//  out_npc     out  32  redirect target; in_pc+4 when out_redir=0
//  csr_ren     out  1   CSR read enable
//  csr_raddr   out  12  CSR read address
//  csr_rdata   in   32  CSR read data (combinational, same cycle)
//  csr_wen     out  1   CSR write enable
//  csr_waddr   out  12  CSR write address
//  csr_wdata   out  32  CSR write data
//  csr_jtype   out  2   2'b01 = ECALL (CSR file loads mcause=11 when csr_wen=0)
// BEHAVIOUR
//  States: IDLE, EXEC, EPC, CAUSE, VEC, RET, DONE. Registered op/csr/src/pc/rd captured on accept.
//  IDLE: in_ready=1; on in_valid -> capture, go EXEC (ops 1-3), EPC (4), RET (5), DONE (0,6,7).
//  EXEC: csr_ren=1,raddr=csr; old=csr_rdata latched to out_rdata. csr_wen=1,waddr=csr,
//   wdata = RW: src; RS: old|src; RC: old&~src. RS/RC with src==0: csr_wen=0. -> DONE.
//  EPC: csr_wen=1, waddr=A_MEPC, wdata=pc -> CAUSE.
//  CAUSE: csr_wen=0, csr_jtype=2'b01 (exactly one cycle) -> VEC.
//  VEC: csr_ren=1, raddr=A_MTVEC; out_npc<=csr_rdata, out_redir<=1 -> DONE.
//  RET: csr_ren=1, raddr=A_MEPC; out_npc<=csr_rdata, out_redir<=1 -> DONE. mstatus untouched.
//  DONE: out_valid=1, outputs stable until out_ready; then -> IDLE (no same-cycle re-accept).
//  Latency accept->out_valid: CSR ops 2, ECALL 4, MRET 2, NOP/reserved 1 cycles.
//  out_rd_wen=1 only for ops 1-3 with rd!=0; 0 for ECALL/MRET/NOP/reserved; out_redir=0 for those.
//  csr_* strobes decoded from state only: 0 in IDLE/DONE; jtype=2'b00 outside CAUSE.
//  csr_raddr/waddr/wdata = 0 when their enable is low.
//  Reset (any state, incl. mid-ECALL): state=IDLE, in_ready=1 next cycle, out_valid=0,
//   out_rd_wen=0, out_redir=0, out_rdata=0, out_npc=0, out_rd=0, all csr strobes 0.
//   A partially sequenced ECALL is abandoned; CSR file is reset by the same reset.
//  out_valid held with out_ready=0: no CSR access, no state change, outputs frozen.
// TESTING
//  CSRRW 0x305 src=0x8000_0100, mtvec=0 -> wen 1 cycle, out_rdata=0, mtvec=0x8000_0100, valid @+2.
//  CSRRS 0x300 src=0x8, mstatus=0x1800 -> wdata=0x1808, out_rdata=0x1800; src=0 -> csr_wen never high.
//  ECALL pc=0x8000_0040, mtvec=0x8000_0100 -> mepc=0x8000_0040, mcause=11, out_npc=0x8000_0100,
//   out_redir=1, out_rd_wen=0, valid 4 cycles after accept.
//  MRET with mepc=0x8000_0044 -> out_npc=0x8000_0044, out_redir=1, no csr_wen.
//  out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, no CSR strobes; then IDLE.
//  reset asserted in CAUSE -> jtype not asserted after reset, all outputs at reset values, IDLE.

Source files
------------

// File: rtl/ysyx_25040111_csr_seq_if.sv
// Decode/writeback/CSR-file signal bundle for the CSR sequencer.
// The sequencer connects on the slave side.
// The environment (decode, writeback and CSR file) connects on the master side.
interface ysyx_25040111_csr_seq_if #(
    parameter int XLEN = 32
);
    // decode -> sequencer
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [11:0]     in_csr;
    logic [XLEN-1:0] in_src;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;

    // sequencer -> writeback
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic            out_rd_wen;
    logic [XLEN-1:0] out_rdata;
    logic            out_redir;
    logic [XLEN-1:0] out_npc;

    // sequencer <-> CSR register file
    logic            csr_ren;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_wen;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic [1:0]      csr_jtype;

    modport slave (
        input  in_valid, in_op, in_csr, in_src, in_pc, in_rd,
        output in_ready,
        output out_valid, out_rd, out_rd_wen, out_rdata, out_redir, out_npc,
        input  out_ready,
        output csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata, csr_jtype,
        input  csr_rdata
    );

    modport master (
        output in_valid, in_op, in_csr, in_src, in_pc, in_rd,
        input  in_ready,
        input  out_valid, out_rd, out_rd_wen, out_rdata, out_redir, out_npc,
        output out_ready,
        input  csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata, csr_jtype,
        output csr_rdata
    );
endinterface

// File: rtl/ysyx_25040111_csr_seq.sv
// Sequences CSRRW/RS/RC, ECALL and MRET onto the CSR file's single read and single write port.
// Latency accept->out_valid: CSR ops 2, ECALL 4, MRET 2, NOP/reserved 1 cycle.
// in_ready only in IDLE; the DONE results are held frozen until out_ready, with no CSR traffic meanwhile.
module ysyx_25040111_csr_seq #(
    parameter int          XLEN    = 32,
    parameter logic [11:0] A_MTVEC = 12'h305,
    parameter logic [11:0] A_MEPC  = 12'h341
) (
    input logic                    clk,
    input logic                    reset,
    ysyx_25040111_csr_seq_if.slave bus
);
    localparam logic [2:0] OP_CSRRW = 3'd1;
    localparam logic [2:0] OP_CSRRS = 3'd2;
    localparam logic [2:0] OP_CSRRC = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_EPC,
        S_CAUSE,
        S_VEC,
        S_RET,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // instruction captured on accept
    logic [2:0]      op_q;
    logic [11:0]     csr_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] pc_q;

    // registered writeback results
    logic [4:0]      out_rd_q;
    logic            out_rd_wen_q;
    logic [XLEN-1:0] out_rdata_q;
    logic            out_redir_q;
    logic [XLEN-1:0] out_npc_q;

    // combinational strobes
    logic            in_ready_c;
    logic            out_valid_c;
    logic            csr_ren_c;
    logic [11:0]     csr_raddr_c;
    logic            csr_wen_c;
    logic [11:0]     csr_waddr_c;
    logic [XLEN-1:0] csr_wdata_c;
    logic [1:0]      csr_jtype_c;

    logic accept;
    logic in_is_csr_op;

    assign accept       = (state == S_IDLE) && bus.in_valid;
    assign in_is_csr_op = (bus.in_op == OP_CSRRW) || (bus.in_op == OP_CSRRS) ||
                          (bus.in_op == OP_CSRRC);

    // State register; a synchronous reset abandons any partly sequenced trap
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and CSR port strobes, all decoded from the current state
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        csr_ren_c   = 1'b0;
        csr_raddr_c = 12'd0;
        csr_wen_c   = 1'b0;
        csr_waddr_c = 12'd0;
        csr_wdata_c = '0;
        csr_jtype_c = 2'b00;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (in_is_csr_op) begin
                        state_nxt = S_EXEC;
                    end else if (bus.in_op == OP_ECALL) begin
                        state_nxt = S_EPC;
                    end else if (bus.in_op == OP_MRET) begin
                        state_nxt = S_RET;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                csr_ren_c   = 1'b1;
                csr_raddr_c = csr_q;
                // set/clear with a zero mask must not write (read-only CSRs stay untouched)
                case (op_q)
                    OP_CSRRW: begin
                        csr_wen_c   = 1'b1;
                        csr_wdata_c = src_q;
                    end
                    OP_CSRRS: begin
                        csr_wen_c   = (src_q != '0);
                        csr_wdata_c = csr_wen_c ? (bus.csr_rdata | src_q) : '0;
                    end
                    OP_CSRRC: begin
                        csr_wen_c   = (src_q != '0);
                        csr_wdata_c = csr_wen_c ? (bus.csr_rdata & ~src_q) : '0;
                    end
                    default: begin
                        csr_wen_c = 1'b0;
                    end
                endcase
                csr_waddr_c = csr_wen_c ? csr_q : 12'd0;
                state_nxt   = S_DONE;
            end
            S_EPC: begin
                csr_wen_c   = 1'b1;
                csr_waddr_c = A_MEPC;
                csr_wdata_c = pc_q;
                state_nxt   = S_CAUSE;
            end
            S_CAUSE: begin
                // CSR file loads mcause=11 itself on this one-cycle pulse
                csr_jtype_c = 2'b01;
                state_nxt   = S_VEC;
            end
            S_VEC: begin
                csr_ren_c   = 1'b1;
                csr_raddr_c = A_MTVEC;
                state_nxt   = S_DONE;
            end
            S_RET: begin
                csr_ren_c   = 1'b1;
                csr_raddr_c = A_MEPC;
                state_nxt   = S_DONE;
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the instruction on accept and build up the writeback result
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q         <= 3'd0;
            csr_q        <= 12'd0;
            src_q        <= '0;
            pc_q         <= '0;
            out_rd_q     <= 5'd0;
            out_rd_wen_q <= 1'b0;
            out_rdata_q  <= '0;
            out_redir_q  <= 1'b0;
            out_npc_q    <= '0;
        end else begin
            if (accept) begin
                op_q         <= bus.in_op;
                csr_q        <= bus.in_csr;
                src_q        <= bus.in_src;
                pc_q         <= bus.in_pc;
                out_rd_q     <= bus.in_rd;
                out_rd_wen_q <= in_is_csr_op && (bus.in_rd != 5'd0);
                out_rdata_q  <= '0;
                out_redir_q  <= 1'b0;
                out_npc_q    <= bus.in_pc + XLEN'(4);
            end
            if (state == S_EXEC) begin
                out_rdata_q <= bus.csr_rdata;
            end
            if ((state == S_VEC) || (state == S_RET)) begin
                out_npc_q   <= bus.csr_rdata;
                out_redir_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_rd_wen = out_rd_wen_q;
    assign bus.out_rdata  = out_rdata_q;
    assign bus.out_redir  = out_redir_q;
    assign bus.out_npc    = out_npc_q;
    assign bus.csr_ren    = csr_ren_c;
    assign bus.csr_raddr  = csr_raddr_c;
    assign bus.csr_wen    = csr_wen_c;
    assign bus.csr_waddr  = csr_waddr_c;
    assign bus.csr_wdata  = csr_wdata_c;
    assign bus.csr_jtype  = csr_jtype_c;
endmodule
